// File: rtl/risc_pkg.sv
// Shared definitions for the 10-bit RISC control unit: opcodes, class masks,
// bus selects, FSM states and instruction field positions.
package risc_pkg;

    localparam int unsigned OP_MSB   = 9;
    localparam int unsigned OP_LSB   = 6;
    localparam int unsigned SRC_MSB  = 5;
    localparam int unsigned SRC_LSB  = 4;
    localparam int unsigned DEST_MSB = 3;
    localparam int unsigned DEST_LSB = 2;

    localparam logic [3:0] OP_NOT     = 4'd4;
    localparam logic [3:0] OP_ILLEGAL = 4'd5;
    localparam logic [3:0] OP_JMP     = 4'd6;
    localparam logic [3:0] OP_BRZ     = 4'd7;

    // Class masks: an opcode belongs to a class when (op & MASK) == PAT.
    localparam logic [3:0] MASK_BRANCH = 4'b1110;
    localparam logic [3:0] PAT_BRANCH  = 4'b0110;
    localparam logic [3:0] MASK_STORE  = 4'b1110;
    localparam logic [3:0] PAT_STORE   = 4'b1000;
    localparam logic [3:0] MASK_LOAD   = 4'b1110;
    localparam logic [3:0] PAT_LOAD    = 4'b1010;
    localparam logic [3:0] MASK_MOV    = 4'b1100;
    localparam logic [3:0] PAT_MOV     = 4'b1100;

    typedef enum logic [2:0] {
        BUS_R0   = 3'd0,
        BUS_R1   = 3'd1,
        BUS_R2   = 3'd2,
        BUS_R3   = 3'd3,
        BUS_PC   = 3'd4,
        BUS_MEM  = 3'd5,
        BUS_NONE = 3'd6
    } bus_sel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FET1,
        S_FET2,
        S_DEC,
        S_EX1,
        S_RD1,
        S_RD2,
        S_WR1
    } state_t;

    function automatic logic op_match(input logic [3:0] op,
                                      input logic [3:0] mask,
                                      input logic [3:0] pat);
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/risc_instr_decode.sv
// Purely combinational opcode classifier and register-field extractor.
module risc_instr_decode
    import risc_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 10
) (
    input  logic [WORD_SIZE-1:0] instr,
    output logic [3:0]           opcode,
    output logic [1:0]           src,
    output logic [1:0]           dest,
    output logic                 is_alu,
    output logic                 is_mov,
    output logic                 is_jmp,
    output logic                 is_brz,
    output logic                 is_load,
    output logic                 is_store,
    output logic                 is_illegal
);

    logic unused_reserved;

    assign opcode = instr[OP_MSB:OP_LSB];
    assign src    = instr[SRC_MSB:SRC_LSB];
    assign dest   = instr[DEST_MSB:DEST_LSB];

    // Bits [1:0] carry no meaning for the control unit.
    assign unused_reserved = ^instr[1:0];

    assign is_alu     = (opcode <= OP_NOT);
    assign is_mov     = op_match(opcode, MASK_MOV, PAT_MOV);
    assign is_jmp     = op_match(opcode, MASK_BRANCH, PAT_BRANCH) && (opcode == OP_JMP);
    assign is_brz     = op_match(opcode, MASK_BRANCH, PAT_BRANCH) && (opcode == OP_BRZ);
    assign is_load    = op_match(opcode, MASK_LOAD, PAT_LOAD);
    assign is_store   = op_match(opcode, MASK_STORE, PAT_STORE);
    assign is_illegal = (opcode == OP_ILLEGAL);

endmodule

// File: rtl/risc_control_unit.sv
// Multi-cycle fetch/decode/execute control FSM for the 10-bit RISC core.
// Optional memory-ack timeout enabled by defining RISC_CU_MEM_TIMEOUT_EN.
module risc_control_unit #(
    parameter int unsigned WORD_SIZE      = 10,
    parameter int unsigned OP_SIZE        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] instr_in,
    input  logic                 zero_flag,
    input  logic                 mem_ack,
    output logic                 load_ir,
    output logic                 load_add_r,
    output logic                 inc_pc,
    output logic                 load_pc,
    output logic                 load_reg_y,
    output logic                 load_reg_z,
    output logic [3:0]           load_reg,
    output logic                 alu_wb,
    output logic [2:0]           bus_sel,
    output logic [OP_SIZE-1:0]   alu_sel,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 illegal_op,
    output logic                 mem_timeout
);

    import risc_pkg::*;

    state_t     state, state_next;
    logic [3:0] opcode;
    logic [1:0] src, dest;
    logic       is_alu, is_mov, is_jmp, is_brz, is_load, is_store, is_illegal;
    logic [3:0] dest_onehot;
    logic       timeout;

    risc_instr_decode #(
        .WORD_SIZE (WORD_SIZE)
    ) u_decode (
        .instr      (instr_in),
        .opcode     (opcode),
        .src        (src),
        .dest       (dest),
        .is_alu     (is_alu),
        .is_mov     (is_mov),
        .is_jmp     (is_jmp),
        .is_brz     (is_brz),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_illegal (is_illegal)
    );

    assign dest_onehot = 4'b0001 << dest;

`ifdef RISC_CU_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait = (state == S_FET2) || (state == S_RD1) ||
                     (state == S_RD2)  || (state == S_WR1);
    // An ack arriving in the limit cycle completes normally.
    assign timeout = in_wait && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || (state_next != state))
            wait_cnt <= '0;
        else if (in_wait)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: state_next = S_FET1;
            S_FET1: state_next = S_FET2;
            S_FET2: if (mem_ack) state_next = S_DEC;
            S_DEC: begin
                if (is_alu)
                    state_next = S_EX1;
                else if (is_jmp || is_brz || is_load || is_store)
                    state_next = S_RD1;
                else
                    state_next = S_FET1;
            end
            S_EX1: state_next = S_FET1;
            S_RD1: begin
                if (mem_ack) begin
                    if (is_load)
                        state_next = S_RD2;
                    else if (is_store)
                        state_next = S_WR1;
                    else
                        state_next = S_FET1;
                end
            end
            S_RD2: if (mem_ack) state_next = S_FET1;
            S_WR1: if (mem_ack) state_next = S_FET1;
            default: state_next = S_IDLE;
        endcase
        if (timeout)
            state_next = S_FET1;
    end

    always_comb begin
        load_ir     = 1'b0;
        load_add_r  = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_reg_y  = 1'b0;
        load_reg_z  = 1'b0;
        load_reg    = '0;
        alu_wb      = 1'b0;
        bus_sel     = BUS_NONE;
        alu_sel     = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        if (!rst) begin
            unique case (state)
                S_IDLE: ;
                S_FET1: begin
                    bus_sel    = BUS_PC;
                    load_add_r = 1'b1;
                end
                S_FET2: begin
                    if (timeout) begin
                        mem_timeout = 1'b1;
                    end else begin
                        mem_rd  = 1'b1;
                        bus_sel = BUS_MEM;
                        if (mem_ack) begin
                            load_ir = 1'b1;
                            inc_pc  = 1'b1;
                        end
                    end
                end
                S_DEC: begin
                    if (is_alu) begin
                        bus_sel    = {1'b0, src};
                        load_reg_y = 1'b1;
                    end else if (is_mov) begin
                        bus_sel  = {1'b0, src};
                        load_reg = dest_onehot;
                    end else if (is_jmp || is_brz || is_load || is_store) begin
                        bus_sel    = BUS_PC;
                        load_add_r = 1'b1;
                    end else if (is_illegal) begin
                        illegal_op = 1'b1;
                    end
                end
                S_EX1: begin
                    bus_sel    = {1'b0, dest};
                    alu_sel    = OP_SIZE'(opcode);
                    load_reg_z = 1'b1;
                    alu_wb     = 1'b1;
                    load_reg   = dest_onehot;
                end
                S_RD1: begin
                    if (timeout) begin
                        mem_timeout = 1'b1;
                    end else begin
                        mem_rd  = 1'b1;
                        bus_sel = BUS_MEM;
                        if (mem_ack) begin
                            if (is_jmp || (is_brz && zero_flag)) begin
                                load_pc = 1'b1;
                            end else begin
                                inc_pc     = 1'b1;
                                load_add_r = is_load || is_store;
                            end
                        end
                    end
                end
                S_RD2: begin
                    if (timeout) begin
                        mem_timeout = 1'b1;
                    end else begin
                        mem_rd  = 1'b1;
                        bus_sel = BUS_MEM;
                        if (mem_ack)
                            load_reg = dest_onehot;
                    end
                end
                S_WR1: begin
                    if (timeout) begin
                        mem_timeout = 1'b1;
                    end else begin
                        mem_wr  = 1'b1;
                        bus_sel = {1'b0, src};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: each cycle's stimulus and expected outputs are queued, then replayed.
module tb_risc_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] instr_in;
    logic       zero_flag;
    logic       mem_ack;
    logic       load_ir, load_add_r, inc_pc, load_pc, load_reg_y, load_reg_z;
    logic [3:0] load_reg;
    logic       alu_wb;
    logic [2:0] bus_sel;
    logic [3:0] alu_sel;
    logic       mem_rd, mem_wr, illegal_op, mem_timeout;

    typedef struct packed {
        logic       load_ir;
        logic       load_add_r;
        logic       inc_pc;
        logic       load_pc;
        logic       load_reg_y;
        logic       load_reg_z;
        logic [3:0] load_reg;
        logic       alu_wb;
        logic [2:0] bus_sel;
        logic [3:0] alu_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       illegal_op;
        logic       mem_timeout;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [9:0] instr;
        logic       zero;
        logic       ack;
        outs_t      exp;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    passes = 0;

    risc_control_unit #(
        .WORD_SIZE      (10),
        .OP_SIZE        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .zero_flag   (zero_flag),
        .mem_ack     (mem_ack),
        .load_ir     (load_ir),
        .load_add_r  (load_add_r),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_reg_y  (load_reg_y),
        .load_reg_z  (load_reg_z),
        .load_reg    (load_reg),
        .alu_wb      (alu_wb),
        .bus_sel     (bus_sel),
        .alu_sel     (alu_sel),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic outs_t sample();
        return '{load_ir, load_add_r, inc_pc, load_pc, load_reg_y, load_reg_z,
                 load_reg, alu_wb, bus_sel, alu_sel, mem_rd, mem_wr, illegal_op, mem_timeout};
    endfunction

    function automatic outs_t o_none();
        outs_t e = '0;
        e.bus_sel = 3'd6;
        return e;
    endfunction

    function automatic outs_t o_fet1();
        outs_t e = o_none();
        e.bus_sel    = 3'd4;
        e.load_add_r = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_memrd();
        outs_t e = o_none();
        e.bus_sel = 3'd5;
        e.mem_rd  = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_fet2_ack();
        outs_t e = o_memrd();
        e.load_ir = 1'b1;
        e.inc_pc  = 1'b1;
        return e;
    endfunction

    task automatic push(input string nm, input logic r, input logic [9:0] ins,
                        input logic z, input logic a, input outs_t e);
        item_t it;
        it.name = nm; it.rst = r; it.instr = ins; it.zero = z; it.ack = a; it.exp = e;
        sb.push_back(it);
    endtask

    task automatic test_reset();
        item_t it;
        outs_t got;
        push("reset_hold0", 1'b1, 10'h3FF, 1'b1, 1'b1, o_none());
        push("reset_hold1", 1'b1, 10'h3FF, 1'b1, 1'b1, o_none());
        push("reset_idle",  1'b0, 10'h000, 1'b0, 1'b0, o_none());
        push("reset_fet1",  1'b0, 10'h000, 1'b0, 1'b0, o_fet1());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rst; instr_in = it.instr; zero_flag = it.zero; mem_ack = it.ack;
            #1;
            got = sample();
            checks++;
            if (got !== it.exp)
                $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
            else
                passes++;
        end
    endtask

    task automatic test_alu();
        logic [3:0] ops[4]   = '{4'd0, 4'd1, 4'd4, 4'd3};
        logic [1:0] srcs[4]  = '{2'd1, 2'd3, 2'd0, 2'd2};
        logic [1:0] dests[4] = '{2'd2, 2'd0, 2'd3, 2'd1};
        item_t it;
        outs_t got, e;
        logic [9:0] ins;
        for (int i = 0; i < 4; i++) begin
            ins = {ops[i], srcs[i], dests[i], 2'b00};
            push("alu_fet2", 1'b0, ins, 1'b0, 1'b1, o_fet2_ack());
            e = o_none(); e.bus_sel = {1'b0, srcs[i]}; e.load_reg_y = 1'b1;
            push("alu_dec", 1'b0, ins, 1'b0, 1'b0, e);
            e = o_none(); e.bus_sel = {1'b0, dests[i]}; e.alu_sel = ops[i];
            e.load_reg_z = 1'b1; e.alu_wb = 1'b1; e.load_reg = 4'b0001 << dests[i];
            push("alu_ex1", 1'b0, ins, 1'b0, 1'b0, e);
            push("alu_next_fet1", 1'b0, ins, 1'b0, 1'b0, o_fet1());
        end
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rst; instr_in = it.instr; zero_flag = it.zero; mem_ack = it.ack;
            #1;
            got = sample();
            checks++;
            if (got !== it.exp)
                $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
            else
                passes++;
        end
    endtask

    task automatic test_mov();
        item_t it;
        outs_t got, e;
        logic [9:0] ins = 10'b1100_10_01_00;
        push("mov_fet2", 1'b0, ins, 1'b0, 1'b1, o_fet2_ack());
        e = o_none(); e.bus_sel = 3'd2; e.load_reg = 4'b0010;
        push("mov_dec", 1'b0, ins, 1'b0, 1'b0, e);
        push("mov_next_fet1", 1'b0, ins, 1'b0, 1'b0, o_fet1());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rst; instr_in = it.instr; zero_flag = it.zero; mem_ack = it.ack;
            #1;
            got = sample();
            checks++;
            if (got !== it.exp)
                $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
            else
                passes++;
        end
    endtask

    task automatic test_branch();
        logic [3:0] ops[3] = '{4'd7, 4'd7, 4'd6};
        logic       zs[3]  = '{1'b0, 1'b1, 1'b0};
        item_t it;
        outs_t got, e;
        logic [9:0] ins;
        for (int i = 0; i < 3; i++) begin
            ins = {ops[i], 6'b0};
            push("br_fet2", 1'b0, ins, ~zs[i], 1'b1, o_fet2_ack());
            push("br_dec", 1'b0, ins, ~zs[i], 1'b0, o_fet1());
            // a no-ack cycle with the opposite flag: the flag only matters in the ack cycle
            push("br_rd1_wait", 1'b0, ins, ~zs[i], 1'b0, o_memrd());
            e = o_memrd();
            if (ops[i] == 4'd6 || zs[i]) e.load_pc = 1'b1; else e.inc_pc = 1'b1;
            push("br_rd1_ack", 1'b0, ins, zs[i], 1'b1, e);
            push("br_next_fet1", 1'b0, ins, zs[i], 1'b0, o_fet1());
        end
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rst; instr_in = it.instr; zero_flag = it.zero; mem_ack = it.ack;
            #1;
            got = sample();
            checks++;
            if (got !== it.exp)
                $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
            else
                passes++;
        end
    endtask

    task automatic test_store_load();
        item_t it;
        outs_t got, e;
        logic [9:0] st = 10'b1000_11_00_00;
        logic [9:0] ld = 10'b1011_00_01_00;
        push("st_fet2", 1'b0, st, 1'b0, 1'b1, o_fet2_ack());
        push("st_dec",  1'b0, st, 1'b0, 1'b0, o_fet1());
        e = o_memrd(); e.inc_pc = 1'b1; e.load_add_r = 1'b1;
        push("st_rd1_ack", 1'b0, st, 1'b0, 1'b1, e);
        e = o_none(); e.mem_wr = 1'b1; e.bus_sel = 3'd3;
        for (int i = 0; i < 4; i++)
            push("st_wr1", 1'b0, st, 1'b0, (i == 3), e);
        push("st_next_fet1", 1'b0, st, 1'b0, 1'b0, o_fet1());
        push("ld_fet2", 1'b0, ld, 1'b0, 1'b1, o_fet2_ack());
        push("ld_dec",  1'b0, ld, 1'b0, 1'b0, o_fet1());
        e = o_memrd(); e.inc_pc = 1'b1; e.load_add_r = 1'b1;
        push("ld_rd1_ack", 1'b0, ld, 1'b0, 1'b1, e);
        e = o_memrd(); e.load_reg = 4'b0010;
        push("ld_rd2_ack", 1'b0, ld, 1'b0, 1'b1, e);
        push("ld_next_fet1", 1'b0, ld, 1'b0, 1'b0, o_fet1());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rst; instr_in = it.instr; zero_flag = it.zero; mem_ack = it.ack;
            #1;
            got = sample();
            checks++;
            if (got !== it.exp)
                $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
            else
                passes++;
        end
    endtask

    task automatic test_illegal();
        item_t it;
        outs_t got, e;
        logic [9:0] ins = 10'b0101_11_11_00;
        push("ill_fet2", 1'b0, ins, 1'b0, 1'b1, o_fet2_ack());
        e = o_none(); e.illegal_op = 1'b1;
        push("ill_dec", 1'b0, ins, 1'b0, 1'b0, e);
        push("ill_next_fet1", 1'b0, ins, 1'b0, 1'b0, o_fet1());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rst; instr_in = it.instr; zero_flag = it.zero; mem_ack = it.ack;
            #1;
            got = sample();
            checks++;
            if (got !== it.exp)
                $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
            else
                passes++;
        end
    endtask

    task automatic test_reset_mid_load();
        item_t it;
        outs_t got, e;
        logic [9:0] ld = 10'b1010_00_10_00;
        push("rl_fet2", 1'b0, ld, 1'b0, 1'b1, o_fet2_ack());
        push("rl_dec",  1'b0, ld, 1'b0, 1'b0, o_fet1());
        e = o_memrd(); e.inc_pc = 1'b1; e.load_add_r = 1'b1;
        push("rl_rd1_ack", 1'b0, ld, 1'b0, 1'b1, e);
        push("rl_rd2_wait", 1'b0, ld, 1'b0, 1'b0, o_memrd());
        push("rl_rst_ack",  1'b1, ld, 1'b0, 1'b1, o_none());
        push("rl_idle",     1'b0, ld, 1'b0, 1'b0, o_none());
        push("rl_fet1",     1'b0, ld, 1'b0, 1'b0, o_fet1());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rst; instr_in = it.instr; zero_flag = it.zero; mem_ack = it.ack;
            #1;
            got = sample();
            checks++;
            if (got !== it.exp)
                $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
            else
                passes++;
        end
    endtask

`ifdef RISC_CU_MEM_TIMEOUT_EN
    task automatic test_timeout();
        item_t it;
        outs_t got, e;
        for (int i = 0; i < 15; i++)
            push("to_fet2_wait", 1'b0, 10'h000, 1'b0, 1'b0, o_memrd());
        e = o_none(); e.mem_timeout = 1'b1;
        push("to_pulse", 1'b0, 10'h000, 1'b0, 1'b0, e);
        push("to_fet1",  1'b0, 10'h000, 1'b0, 1'b0, o_fet1());
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clk);
            rst = it.rst; instr_in = it.instr; zero_flag = it.zero; mem_ack = it.ack;
            #1;
            got = sample();
            checks++;
            if (got !== it.exp)
                $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
            else
                passes++;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_in = '0; zero_flag = 1'b0; mem_ack = 1'b0;
        test_reset();
        test_alu();
        test_mov();
        test_branch();
        test_store_load();
        test_illegal();
        test_reset_mid_load();
`ifdef RISC_CU_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
- Multi-cycle control FSM for the 10-bit-instruction RISC core.
- Sits opposite the ALU/datapath. Fetches and decodes instructions, then sequences register, bus and memory strobes.
- Drives the ALU opcode select and consumes the registered zero flag.
- Handshakes with instruction/data memory through a request/ack pair.

Parameters:
WORD_SIZE, 10, instruction width.
OP_SIZE, 4, opcode width (instr[9:6]).
TIMEOUT_CYCLES, 16, mem_ack wait limit; used only with the optional feature.

Ports:
clk  in  1  single clock, all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
instr_in  in  10  current IR contents: opcode [9:6], src [5:4], dest [3:2], [1:0] reserved.
zero_flag  in  1  Reg_Z zero flag from the datapath.
mem_ack  in  1  memory completed the current read/write this cycle.
load_ir  out  1  capture the memory bus into IR.
load_add_r  out  1  capture the bus into the address register.
inc_pc  out  1  PC <= PC+1.
load_pc  out  1  PC <= bus.
load_reg_y  out  1  Reg_Y <= bus.
load_reg_z  out  1  Reg_Z <= ALU zero result.
load_reg  out  4  one-hot register-file write enable R0..R3.
alu_wb  out  1  register-file write data comes from ALU out (else from bus).
bus_sel  out  3  0..3 = R0..R3, 4 = PC, 5 = MEM, 6 = none.
alu_sel  out  4  ALU opcode.
mem_rd  out  1  memory read request, held until ack.
mem_wr  out  1  memory write request, held until ack.
illegal_op  out  1  one-cycle pulse on an undefined opcode.
mem_timeout  out  1  one-cycle pulse on a memory timeout (optional feature).

Behaviour:
- Outputs are combinational from the registered state plus instr_in, zero_flag and mem_ack.
- While rst=1, all outputs are forced to 0 (bus_sel=6) in the same cycle; the state becomes S_IDLE at the edge.
- Reset mid-operation abandons the instruction, and mem_rd/mem_wr drop immediately. PC and registers are the datapath's responsibility.
- Opcodes:
  - ALU ops: ADD=0, SUB=1, AND=2, OR=3, NOT=4.
  - JMP=6, BRZ=7.
  - STORE=8/9, LOAD=10/11.
  - MOV (SAVE)=12..15.
  - 5 is illegal.
- S_IDLE: no strobes -> S_FET1.
- S_FET1: bus_sel=4, load_add_r -> S_FET2.
- S_FET2: mem_rd, bus_sel=5. Without ack, stay. On ack: load_ir, inc_pc -> S_DEC.
- S_DEC, by opcode:
  - ALU op: bus_sel=src, load_reg_y -> S_EX1.
  - MOV: bus_sel=src, load_reg[dest] -> S_FET1.
  - JMP/BRZ/LOAD/STORE: bus_sel=4, load_add_r -> S_RD1.
  - Opcode 5: illegal_op=1 -> S_FET1 (NOP).
- S_EX1: bus_sel=dest, alu_sel=opcode, load_reg_z, alu_wb, load_reg[dest] -> S_FET1. SUB result is dest-src per ALU convention; NOT ignores the dest value.
- S_RD1 (second word): mem_rd, bus_sel=5; wait for ack. On ack, by opcode:
  - JMP: load_pc -> S_FET1.
  - BRZ with zero_flag=1 (sampled in the ack cycle): load_pc -> S_FET1.
  - BRZ with zero_flag=0: inc_pc -> S_FET1.
  - LOAD: inc_pc, load_add_r -> S_RD2.
  - STORE: inc_pc, load_add_r -> S_WR1.
- S_RD2: mem_rd, bus_sel=5; on ack load_reg[dest] (alu_wb=0) -> S_FET1.
- S_WR1: mem_wr, bus_sel=src; on ack -> S_FET1.
- mem_rd and mem_wr are never both high. load_pc and inc_pc are never both high.
- Cycle counts with zero-wait memory (one ack per request):
  - ALU op: 4.
  - MOV: 3.
  - JMP/BRZ: 4.
  - LOAD/STORE: 5.
- load_reg is one-hot or zero, never multi-hot.

Optional Feature:
- Macro: RISC_CU_MEM_TIMEOUT_EN.
- Defined:
  - A counter resets on entry to any wait state (FET2, RD1, RD2, WR1) and counts cycles without ack.
  - When it reaches TIMEOUT_CYCLES: mem_timeout pulses 1 cycle, the request drops, the instruction is abandoned -> S_FET1.
  - An ack in the same cycle as the limit wins.
- Undefined: waits indefinitely, and mem_timeout is tied to 0. The port exists in both builds.

Decomposition:
- Package risc_pkg:
  - opcode constants and class masks (JMP 011x, STORE 100x, LOAD 101x, MOV 11xx);
  - bus_sel encodings;
  - state enum;
  - instruction field positions.
- Sub-module risc_instr_decode: purely combinational opcode classifier (is_alu, is_mov, is_jmp, is_brz, is_load, is_store, is_illegal, src, dest).

Test Plan:
1. Reset: rst=1 for 2 cycles -> all outputs 0, bus_sel=6; release -> S_IDLE then S_FET1 with bus_sel=4, load_add_r=1.
2. ADD R1->R2 (instr 0000_01_10_00), immediate ack:
   - DEC: bus_sel=1, load_reg_y.
   - EX1: alu_sel=0, bus_sel=2, load_reg=4'b0100, load_reg_z, alu_wb.
   - Next fetch 4 cycles after FET1.
3. BRZ (0111) with zero_flag=0 -> inc_pc, no load_pc. Repeat with zero_flag=1 -> load_pc=1 in the RD1 ack cycle.
4. STORE R3 with mem_ack delayed 3 cycles in WR1 -> mem_wr=1 for 4 cycles, bus_sel=3, then S_FET1.
5. Opcode 5 -> illegal_op high exactly 1 cycle in DEC; the following cycle is FET1.
6. rst raised during LOAD's RD2 wait -> mem_rd=0 same cycle, no load_reg. With RISC_CU_MEM_TIMEOUT_EN and no ack for 16 cycles -> mem_timeout pulse, then FET1.
